v4_pulse_gen: RTL and testbench
===============================

# v4_pulse_gen

Synthetic detector-pulse source for the v4 shaping chain. It produces one ADC-format sample per clock: a flat baseline, a linear rise, then an exponential decay, which emulates a charge-preamp pulse. Its output connects directly to the trapezoidal filter's `input_data` for closed-loop testing on the bench and in hardware. Pulses are requested through a ready/start handshake, and pile-up on a decaying tail is supported.

## Interface
- `SIZE_ADC_DATA`, 12, sample width; matches the filter input.
- `BASELINE`, 100, constant offset added to every sample.
- `RISE_SHIFT`, 2, rise lasts 2^RISE_SHIFT cycles.
- `DECAY_SHIFT`, 4, per-cycle decay is acc >> DECAY_SHIFT; sets tau ≈ 2^DECAY_SHIFT cycles.
- `FRAC`, 8, fractional bits in the accumulator.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-low; clock clk.
- `start` in 1: pulse request, sampled only when ready=1.
- `amplitude` in SIZE_ADC_DATA: pulse height in ADC counts, sampled with start.
- `ready` out 1: generator can accept a pulse.
- `output_data` out SIZE_ADC_DATA: sample stream.
- `pulse_count` out 16: number of accepted pulses; wraps at 2^16.

## Operation
- Accumulator `acc`: unsigned, SIZE_ADC_DATA+FRAC+1 bits. Every update clamps `acc` to at most (2^SIZE_ADC_DATA−1)<<FRAC.
- A pulse is accepted on any edge where reset=1, start=1 and ready=1.
- Acceptance does three things:
  - latches step = (amplitude<<FRAC)>>RISE_SHIFT;
  - clears rise_cnt;
  - increments pulse_count and moves the state to RISE.
- `ready` is combinational: reset=1 and state≠RISE.
- States:
  - IDLE: acc=0. Accepting a pulse moves to RISE.
  - RISE: each edge, acc += step and rise_cnt++. After the 2^RISE_SHIFT-th addition, move to DECAY. start is ignored here (ready=0).
  - DECAY: each edge, acc −= max(acc>>DECAY_SHIFT, 1). If acc>>FRAC is 0 before the update, set acc to 0 and go to IDLE. Accepting a pulse moves to RISE with acc kept (pile-up). Acceptance takes priority over the decay update on that edge.
- Output: registered value of min(BASELINE + (acc>>FRAC), 2^SIZE_ADC_DATA−1).
- amplitude=0 is a legal pulse: it runs the full RISE with step 0 and is counted.

## Timing
- Reset values: acc=0, state=IDLE, rise_cnt=0, output_data=0, pulse_count=0. ready=0 while reset=0.
- The first edge after reset release sets output_data=BASELINE.
- Let the acceptance edge be E0:
  - acc is updated on edges E1..E(2^RISE_SHIFT);
  - output_data shows the acc value from edge En at edge En+1;
  - the peak appears at E(2^RISE_SHIFT+1);
  - ready is 0 from E0 through E(2^RISE_SHIFT) and returns to 1 after that edge.
- Latency from acc to output_data is 1 cycle. Throughput is one sample per clock, always.
- Reset asserted mid-pulse takes effect at the next edge: all state returns to reset values and any pending pulse is discarded.

## Configuration
- `V4_PULSE_GEN_NOISE_EN` defined:
  - adds a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded to 16'hACE1 on reset and advancing every cycle;
  - adds signed noise n = lfsr[2:0]−4 (range −4..+3) to the output sum before clamping to [0, 2^SIZE_ADC_DATA−1].
- Not defined: no LFSR; the output is deterministic as described above.

## Test plan
All scenarios use default parameters and have the macro undefined unless stated.

- Reset: hold reset=0 for 5 cycles → output_data=0, ready=0, pulse_count=0. Release → output_data=100 after the first edge; ready=1.
- Single pulse: start with amplitude=400 → output 200, 300, 400, 500 on E2..E5, then 475 (acc 96000) on E6. The output decays monotonically to 100, the state returns to IDLE, pulse_count=1, and ready=0 only during E0..E4.
- Start during RISE: assert start at E2 of a pulse → ignored; pulse_count is unchanged and the waveform is identical to the single-pulse case.
- Pile-up: accept amplitude=400 when the output reads 475 (acc integer 375) → the next peak is 875, then decay resumes; pulse_count=2.
- Saturation: accept amplitude=4095, then another 4095 in DECAY → output_data clamps at 4095 and never wraps.
- Reset mid-RISE: drive reset=0 at E2 → the next edge gives output_data=0 and pulse_count=0. After release the output is 100 with no residual tail.

Source files
------------

// File: rtl/v4_pulse_gen.sv
// Synthetic preamp-style pulse source: baseline, linear rise, exponential decay, with pile-up.
// Optional output noise from a 16-bit LFSR is enabled by defining V4_PULSE_GEN_NOISE_EN.
module v4_pulse_gen #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int BASELINE      = 100,
  parameter int RISE_SHIFT    = 2,
  parameter int DECAY_SHIFT   = 4,
  parameter int FRAC          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic                     ready,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic [15:0]              pulse_count
);

  localparam int ACC_W = SIZE_ADC_DATA + FRAC + 1;
  localparam int RC_W  = RISE_SHIFT + 1;
  localparam int SW    = SIZE_ADC_DATA + 3;
  localparam logic [RC_W-1:0]          RISE_LAST = RC_W'((1 << RISE_SHIFT) - 1);
  localparam logic [ACC_W-1:0]         ACC_MAX   = {1'b0, {SIZE_ADC_DATA{1'b1}}, {FRAC{1'b0}}};
  localparam logic [SIZE_ADC_DATA-1:0] OUT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         step;
  logic [ACC_W-1:0]         new_step;
  logic [ACC_W-1:0]         rise_next;
  logic [ACC_W-1:0]         dec_amt;
  logic [ACC_W-1:0]         acc_dec;
  logic [ACC_W:0]           acc_sum;
  logic [SIZE_ADC_DATA:0]   acc_int;
  logic [SW-1:0]            out_sum;
  logic [SIZE_ADC_DATA-1:0] out_next;
  logic [RC_W-1:0]          rise_cnt;
  logic                     accept;

  assign ready  = reset && (state != RISE);
  assign accept = start && ready;

  assign new_step  = (ACC_W'(amplitude) << FRAC) >> RISE_SHIFT;
  assign acc_sum   = {1'b0, acc} + {1'b0, step};
  assign rise_next = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[ACC_W-1:0];
  assign dec_amt   = ((acc >> DECAY_SHIFT) == '0) ? ACC_W'(1) : (acc >> DECAY_SHIFT);
  assign acc_dec   = acc - dec_amt;
  assign acc_int   = acc[ACC_W-1:FRAC];

`ifdef V4_PULSE_GEN_NOISE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Noise term lfsr[2:0]-4 spans -4..+3; the sum may go negative before clamping.
  assign out_sum = SW'(BASELINE) + SW'(acc_int) + SW'(lfsr[2:0]) - SW'(4);
`else
  assign out_sum = SW'(BASELINE) + SW'(acc_int);
`endif

  assign out_next = out_sum[SW-1] ? '0 :
                    (out_sum[SW-2:0] > (SW-1)'(OUT_MAX)) ? OUT_MAX :
                    out_sum[SIZE_ADC_DATA-1:0];

  // Acceptance in DECAY keeps acc so a new pulse stacks on the remaining tail.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      step        <= '0;
      rise_cnt    <= '0;
      output_data <= '0;
      pulse_count <= '0;
    end else begin
      output_data <= out_next;
      case (state)
        IDLE: begin
          acc <= '0;
          if (accept) begin
            step        <= new_step;
            rise_cnt    <= '0;
            pulse_count <= pulse_count + 16'd1;
            state       <= RISE;
          end
        end
        RISE: begin
          acc      <= rise_next;
          rise_cnt <= rise_cnt + 1'b1;
          if (rise_cnt == RISE_LAST) state <= DECAY;
        end
        DECAY: begin
          if (accept) begin
            step        <= new_step;
            rise_cnt    <= '0;
            pulse_count <= pulse_count + 16'd1;
            state       <= RISE;
          end else if (acc_int == '0) begin
            acc   <= '0;
            state <= IDLE;
          end else begin
            acc <= acc_dec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v4_pulse_gen.sv
// Table-driven self-checking bench for v4_pulse_gen with an expectation queue scoreboard.
module tb_v4_pulse_gen;

  typedef struct {
    logic        rst;
    logic        st;
    logic [11:0] amp;
    logic [11:0] eout;
    logic        erdy;
    logic [15:0] ecnt;
    string       tag;
  } vec_t;

  typedef struct {
    logic [11:0] eout;
    logic        erdy;
    logic [15:0] ecnt;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] amplitude = '0;
  logic        ready;
  logic [11:0] output_data;
  logic [15:0] pulse_count;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  v4_pulse_gen dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .amplitude(amplitude),
    .ready(ready),
    .output_data(output_data),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic s, input int amp, input int eout,
                        input logic erdy, input int ecnt, input string tag);
    vec_t v;
    v.rst = r; v.st = s; v.amp = 12'(amp);
    v.eout = 12'(eout); v.erdy = erdy; v.ecnt = 16'(ecnt); v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset = v.rst;
    start = v.st;
    amplitude = v.amp;
    e.eout = v.eout; e.erdy = v.erdy; e.ecnt = v.ecnt; e.tag = v.tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checkVal("scoreboard empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    checkVal({e.tag, " output_data"}, int'(output_data), int'(e.eout));
    checkVal({e.tag, " ready"}, int'(ready), int'(e.erdy));
    checkVal({e.tag, " pulse_count"}, int'(pulse_count), int'(e.ecnt));
  endtask

  task automatic runTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput();
    end
    vecs.delete();
  endtask

  // Let the tail decay on its own, checking it never rises and lands on baseline.
  task automatic waitBaseline(input int ecnt, input string tag);
    int prev;
    int nonmono;
    bit done;
    reset = 1'b1;
    start = 1'b0;
    prev = int'(output_data);
    nonmono = 0;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
      if (int'(output_data) > prev) nonmono++;
      prev = int'(output_data);
      if (output_data == 12'd100) done = 1;
    end
    checkVal({tag, " decay reached baseline"}, int'(output_data), 100);
    checkVal({tag, " decay monotonic violations"}, nonmono, 0);
    repeat (2) @(posedge clk);
    #1;
    checkVal({tag, " idle output"}, int'(output_data), 100);
    checkVal({tag, " idle ready"}, int'(ready), 1);
    checkVal({tag, " idle pulse_count"}, int'(pulse_count), ecnt);
  endtask

  initial begin
    // Reset, then a single 400-count pulse with start asserted during RISE.
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 0, 0, "reset");
    addVec(1, 0, 0,    100, 1, 1 - 1, "release");
    addVec(1, 0, 0,    100, 1, 0, "idle");
    addVec(1, 1, 400,  100, 0, 1, "single E0");
    addVec(1, 0, 0,    100, 0, 1, "single E1");
    addVec(1, 1, 4000, 200, 0, 1, "single E2 start ignored");
    addVec(1, 1, 4000, 300, 0, 1, "single E3 start ignored");
    addVec(1, 0, 0,    400, 1, 1, "single E4");
    addVec(1, 0, 0,    500, 1, 1, "single E5 peak");
    addVec(1, 0, 0,    475, 1, 1, "single E6");
    runTable();
    waitBaseline(1, "single");

    // Pile-up: second pulse accepted on the edge that shows 475.
    addVec(1, 1, 400, 100, 0, 2, "pileup E0");
    addVec(1, 0, 0,   100, 0, 2, "pileup E1");
    addVec(1, 0, 0,   200, 0, 2, "pileup E2");
    addVec(1, 0, 0,   300, 0, 2, "pileup E3");
    addVec(1, 0, 0,   400, 1, 2, "pileup E4");
    addVec(1, 0, 0,   500, 1, 2, "pileup E5");
    addVec(1, 1, 400, 475, 0, 3, "pileup E6 accept");
    addVec(1, 0, 0,   475, 0, 3, "pileup E7");
    addVec(1, 0, 0,   575, 0, 3, "pileup E8");
    addVec(1, 0, 0,   675, 0, 3, "pileup E9");
    addVec(1, 0, 0,   775, 1, 3, "pileup E10");
    addVec(1, 0, 0,   875, 1, 3, "pileup E11 peak");
    addVec(1, 0, 0,   826, 1, 3, "pileup E12");
    runTable();
    waitBaseline(3, "pileup");

    // Saturation: full-scale pulse, then another on its tail.
    addVec(1, 1, 4095, 100,  0, 4, "sat E0");
    addVec(1, 0, 0,    100,  0, 4, "sat E1");
    addVec(1, 0, 0,    1123, 0, 4, "sat E2");
    addVec(1, 0, 0,    2147, 0, 4, "sat E3");
    addVec(1, 0, 0,    3171, 1, 4, "sat E4");
    addVec(1, 0, 0,    4095, 1, 4, "sat E5 clamp");
    addVec(1, 1, 4095, 3939, 0, 5, "sat E6 accept");
    addVec(1, 0, 0,    3939, 0, 5, "sat E7");
    addVec(1, 0, 0,    4095, 0, 5, "sat E8 clamp");
    addVec(1, 0, 0,    4095, 0, 5, "sat E9 clamp");
    addVec(1, 0, 0,    4095, 1, 5, "sat E10 clamp");
    addVec(1, 0, 0,    4095, 1, 5, "sat E11 clamp");
    addVec(1, 0, 0,    3939, 1, 5, "sat E12");
    runTable();
    waitBaseline(5, "sat");

    // Zero-amplitude pulse is counted and holds ready low through RISE.
    addVec(1, 1, 0, 100, 0, 6, "zero E0");
    addVec(1, 0, 0, 100, 0, 6, "zero E1");
    addVec(1, 0, 0, 100, 0, 6, "zero E2");
    addVec(1, 0, 0, 100, 0, 6, "zero E3");
    addVec(1, 0, 0, 100, 1, 6, "zero E4");
    addVec(1, 0, 0, 100, 1, 6, "zero E5");
    addVec(1, 0, 0, 100, 1, 6, "zero E6");
    runTable();

    // Reset mid-RISE discards the pulse and leaves no tail.
    addVec(1, 1, 400, 100, 0, 7, "rstmid E0");
    addVec(1, 0, 0,   100, 0, 7, "rstmid E1");
    addVec(0, 0, 0,   0,   0, 0, "rstmid E2 reset");
    addVec(1, 0, 0,   100, 1, 0, "rstmid E3 release");
    addVec(1, 0, 0,   100, 1, 0, "rstmid E4");
    addVec(1, 0, 0,   100, 1, 0, "rstmid E5");
    addVec(1, 0, 0,   100, 1, 0, "rstmid E6");
    runTable();

    checkVal("scoreboard drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
